// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and pointer sizing for the modport FIFO
package fifo_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_WIDTH = 8;

    // Pointers carry one extra wrap bit above the index bits.
    localparam int PTR_W = $clog2(DEF_DEPTH) + 1;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH register array, synchronous write and registered read
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array is deliberately left out of reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/modport_fifo.sv
// rtl/modport_fifo.sv - synchronous FIFO with wrap-bit pointers and combinational flags
module modport_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_en,
    input  logic             r_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PW    = IDX_W + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_accept;
    logic          rd_accept;

    // rst_n is active-high despite its name.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

    // Full gates writes and empty gates reads, which also settles the
    // simultaneous request cases at both boundaries.
    assign wr_accept = w_en && !full;
    assign rd_accept = r_en && !empty;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst_n),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[IDX_W-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr[IDX_W-1:0]),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_modport_fifo.sv
// tb/tb_modport_fifo.sv - self-checking bench for modport_fifo against a queue model
module tb_modport_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             w_en;
    logic             r_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_dout;

    always #5 clk = ~clk;

    modport_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    function automatic bit m_full();
        return q.size() == DEPTH;
    endfunction

    function automatic bit m_empty();
        return q.size() == 0;
    endfunction

    // Drive one cycle from a negedge and advance the model at the posedge.
    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
        bit was_full;
        bit was_empty;
        w_en      = w;
        r_en      = r;
        data_in   = d;
        was_full  = m_full();
        was_empty = m_empty();
        @(posedge clk);
        if (r && !was_empty) exp_dout = q.pop_front();
        if (w && !was_full) q.push_back(d);
        @(negedge clk);
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        exp_dout = '0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++;
        if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", data_out); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 8'(i));
            checks++;
            if (full !== (i == 8) || empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_flags write %0d got full=%b empty=%b want full=%b empty=0", i, full, empty, (i == 8));
            end
        end
        step(1'b1, 1'b0, 8'hFF);
        checks++;
        if (full !== 1'b1 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL fill_overflow got full=%b dout=%h want full=1 dout=00", full, data_out);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== 8'(i) || empty !== (i == 8) || full !== 1'b0) begin
                errors++;
                $display("FAIL drain read %0d got dout=%h empty=%b full=%b want dout=%h empty=%b full=0",
                         i, data_out, empty, full, 8'(i), (i == 8));
            end
        end
        step(1'b0, 1'b1, '0);
        checks++;
        if (data_out !== 8'h08 || empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_underflow got dout=%h empty=%b want dout=08 empty=1", data_out, empty);
        end
    endtask

    task automatic test_wrap();
        int plan[4] = '{5, 5, 6, 6};
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < plan[p]; k++) begin
                if (p % 2 == 0) step(1'b1, 1'b0, 8'($urandom));
                else            step(1'b0, 1'b1, '0);
                checks++;
                if (data_out !== exp_dout || full !== m_full() || empty !== m_empty()) begin
                    errors++;
                    $display("FAIL wrap phase %0d op %0d got dout=%h full=%b empty=%b want dout=%h full=%b empty=%b",
                             p, k, data_out, full, empty, exp_dout, m_full(), m_empty());
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [WIDTH-1:0] oldest;
        logic [WIDTH-1:0] held;
        // Both requests while empty: only the write lands.
        held = data_out;
        step(1'b1, 1'b1, 8'h3C);
        checks++;
        if (empty !== 1'b0 || data_out !== held) begin
            errors++;
            $display("FAIL simul_empty got empty=%b dout=%h want empty=0 dout=%h", empty, data_out, held);
        end
        for (int i = 1; i < DEPTH; i++) step(1'b1, 1'b0, 8'($urandom));
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL simul_prefill full=%b want 1", full); end
        oldest = q[0];
        step(1'b1, 1'b1, 8'hAA);
        checks++;
        if (data_out !== oldest || full !== 1'b0) begin
            errors++;
            $display("FAIL simul_full got dout=%h full=%b want dout=%h full=0", data_out, full, oldest);
        end
        while (!m_empty()) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== exp_dout || empty !== m_empty()) begin
                errors++;
                $display("FAIL simul_drain got dout=%h empty=%b want dout=%h empty=%b", data_out, empty, exp_dout, m_empty());
            end
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'($urandom));
        checks++;
        if (data_out !== exp_dout || full !== 1'b0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL simul_mid got dout=%h full=%b empty=%b want dout=%h full=0 empty=0", data_out, full, empty, exp_dout);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== exp_dout || empty !== (i == 3)) begin
                errors++;
                $display("FAIL simul_occ3 read %0d got dout=%h empty=%b want dout=%h empty=%b", i, data_out, empty, exp_dout, (i == 3));
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'($urandom));
        #2 rst_n = 1'b1;
        #1;
        q.delete();
        exp_dout = '0;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL midreset_async got empty=%b full=%b dout=%h want empty=1 full=0 dout=00", empty, full, data_out);
        end
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, '0);
            checks++;
            if (data_out !== 8'h00 || empty !== 1'b1) begin
                errors++;
                $display("FAIL midreset_read got dout=%h empty=%b want dout=00 empty=1", data_out, empty);
            end
        end
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, '0);
        checks++;
        if (data_out !== 8'h5A || empty !== 1'b1) begin
            errors++;
            $display("FAIL midreset_resume got dout=%h empty=%b want dout=5a empty=1", data_out, empty);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            checks++;
            if (data_out !== exp_dout || full !== m_full() || empty !== m_empty()) begin
                errors++;
                $display("FAIL random cycle %0d got dout=%h full=%b empty=%b want dout=%h full=%b empty=%b",
                         n, data_out, full, empty, exp_dout, m_full(), m_empty());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modport_fifo.md
MODPORT_FIFO -- requirements
Module: modport_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of storage entries; a power of two, at least 2.
REQ-002 Parameter WIDTH, default 8: data word width in bits.
REQ-003 clk  input  1  single clock; all sequential logic on posedge.
REQ-004 rst_n  input  1  reset, asynchronous and active-high: asserted when 1, despite the name.
REQ-005 w_en  input  1  write request, sampled at posedge clk.
REQ-006 r_en  input  1  read request, sampled at posedge clk.
REQ-007 data_in  input  WIDTH  write data, sampled with w_en.
REQ-008 data_out  output  WIDTH  registered read data.
REQ-009 full  output  1  high when DEPTH entries are stored.
REQ-010 empty  output  1  high when zero entries are stored.

Function
REQ-011 Storage SHALL be a DEPTH x WIDTH array with write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH)+1 bits wide; the MSB is a wrap bit.
REQ-012 Write: at posedge with w_en=1 and full=0, mem[wr_ptr index] <= data_in and wr_ptr increments.
REQ-013 Read: at posedge with r_en=1 and empty=0, data_out <= mem[rd_ptr index] and rd_ptr increments; data is valid one cycle after the request (latency 1).
REQ-014 data_out SHALL hold its last value when no read is accepted.
REQ-015 empty SHALL be combinational: wr_ptr == rd_ptr.
REQ-016 full SHALL be combinational: index bits equal and wrap bits differ.
REQ-017 Write when full is ignored: memory, wr_ptr and flags are unchanged, and no error is raised.
REQ-018 Read when empty is ignored: rd_ptr and data_out are unchanged.
REQ-019 Simultaneous w_en and r_en when neither full nor empty: both are accepted; the occupancy count and flags are unchanged.
REQ-020 Simultaneous w_en and r_en when full: only the read is accepted, and full deasserts in the next cycle.
REQ-021 Simultaneous w_en and r_en when empty: only the write is accepted, and empty deasserts in the next cycle.
REQ-022 Pointer index wraps from DEPTH-1 to 0 and toggles the wrap bit; data order remains strictly FIFO across the wrap.
REQ-023 Storage SHALL have no read-during-write bypass: a word written in cycle N is readable at the earliest in cycle N+1.

Reset
REQ-024 When rst_n=1, wr_ptr and rd_ptr SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-025 When rst_n=1, data_out SHALL clear to 0, giving empty=1 and full=0.
REQ-026 Memory contents are not reset.
REQ-027 Reset asserted mid-operation discards all stored data; the first posedge after rst_n returns to 0 accepts requests normally.

Structure
REQ-028 A shared package fifo_pkg SHALL hold the DEPTH and WIDTH defaults and the localparam PTR_W = $clog2(DEPTH)+1.
REQ-029 A single sub-module fifo_mem SHALL implement the storage array: a synchronous-write, synchronous-read register array.
REQ-030 Pointer, flag and control logic SHALL reside in modport_fifo.
REQ-031 Inputs are driven away from the posedge (for example at negedge plus a small output delay); the design SHALL not depend on input timing beyond standard posedge setup and hold.

Verification
REQ-032 Reset: assert rst_n=1 for 2 cycles, then release -> empty=1, full=0, data_out=0.
REQ-033 Fill: 8 writes of 0x01..0x08 -> full=1 after the 8th write; a 9th write of 0xFF is ignored.
REQ-034 Drain: 8 reads after fill -> data_out=0x01..0x08 in order, then empty=1; a 9th read leaves data_out=0x08.
REQ-035 Wrap: write 5, read 5, write 6, read 6 -> all data in order; flags correct at each step.
REQ-036 Simultaneous: when full, assert w_en=1 and r_en=1 with data_in=0xAA -> read returns the oldest word, the write is dropped, full=0; at occupancy 3, both asserted -> occupancy stays 3.
REQ-037 Mid-reset: write 4 words, assert rst_n -> empty=1 immediately; subsequent reads return nothing new.
